// File: rtl/me_job_sched.sv
// Job scheduler for the 4x4 SAD motion-estimation engine: fetches block and
// search-area pixels per job entry, collects the two-beat vector, hands it on.
module me_job_sched #(
   parameter int ADDR_W   = 16,
   parameter int N_W      = 8,
   parameter int WAIT_MAX = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [N_W-1:0]           num_blk,
   input  logic [ADDR_W-1:0]        blk_base,
   input  logic [ADDR_W-1:0]        area_base,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   output logic                     mem_rd,
   output logic [ADDR_W-1:0]        mem_addr,
   input  logic [7:0]               mem_rdata,
   output logic                     me_block_valid,
   output logic                     me_area_valid,
   output logic [7:0]               me_data,
   input  logic                     me_out_valid,
   input  logic signed [2:0]        me_out_vector,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [N_W-1:0]           res_idx,
   output logic signed [2:0]        res_mvx,
   output logic signed [2:0]        res_mvy
);

   typedef enum logic [2:0] {IDLE, FETCH, WAIT, RES, DONE} state_t;

   localparam int TW = $clog2(WAIT_MAX + 1) + 1;

   state_t              state;
   logic [N_W-1:0]      num_blk_l;
   logic [N_W-1:0]      blk_i;
   logic [ADDR_W-1:0]   blk_base_l;
   logic [ADDR_W-1:0]   area_base_l;
   logic [6:0]          rd_cnt;
   logic                rd_blk;
   logic                got_x;
   logic [TW-1:0]       t_cnt;

   // Address of read rc (0..15 block pixels, 16..79 area pixels) for block idx.
   function automatic logic [ADDR_W-1:0] pix_addr(input logic [ADDR_W-1:0] bb,
                                                  input logic [ADDR_W-1:0] ab,
                                                  input logic [N_W-1:0]    idx,
                                                  input logic [6:0]        rc);
      logic [ADDR_W-1:0] ix;
      ix = ADDR_W'(idx);
      if (rc < 7'd16)
         return bb + (ix << 4) + ADDR_W'(rc);
      else
         return ab + (ix << 6) + ADDR_W'(rc - 7'd16);
   endfunction

   assign me_data = mem_rdata;
   assign res_idx = blk_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         busy           <= 1'b0;
         done           <= 1'b0;
         err            <= 1'b0;
         mem_rd         <= 1'b0;
         mem_addr       <= '0;
         me_block_valid <= 1'b0;
         me_area_valid  <= 1'b0;
         res_valid      <= 1'b0;
         res_mvx        <= '0;
         res_mvy        <= '0;
         num_blk_l      <= '0;
         blk_i          <= '0;
         blk_base_l     <= '0;
         area_base_l    <= '0;
         rd_cnt         <= '0;
         rd_blk         <= 1'b0;
         got_x          <= 1'b0;
         t_cnt          <= '0;
      end else begin
         // Pixel strobes trail the read strobe by the one-cycle memory latency.
         me_block_valid <= mem_rd & rd_blk;
         me_area_valid  <= mem_rd & ~rd_blk;
         done           <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  num_blk_l   <= num_blk;
                  blk_base_l  <= blk_base;
                  area_base_l <= area_base;
                  err         <= 1'b0;
                  blk_i       <= '0;
                  busy        <= 1'b1;
                  if (num_blk == '0) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     mem_rd   <= 1'b1;
                     mem_addr <= blk_base;
                     rd_blk   <= 1'b1;
                     rd_cnt   <= 7'd1;
                     state    <= FETCH;
                  end
               end
            end
            FETCH: begin
               if (rd_cnt == 7'd80) begin
                  mem_rd <= 1'b0;
                  t_cnt  <= '0;
                  got_x  <= 1'b0;
                  state  <= WAIT;
               end else begin
                  mem_addr <= pix_addr(blk_base_l, area_base_l, blk_i, rd_cnt);
                  rd_blk   <= (rd_cnt < 7'd16);
                  rd_cnt   <= rd_cnt + 7'd1;
               end
            end
            WAIT: begin
               t_cnt <= t_cnt + TW'(1);
               if (got_x) begin
                  if (me_out_valid) begin
                     res_mvy   <= me_out_vector;
                     res_valid <= 1'b1;
                     state     <= RES;
                  end else begin
                     err   <= 1'b1;
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end else if (me_out_valid) begin
                  res_mvx <= me_out_vector;
                  got_x   <= 1'b1;
               end else if (t_cnt == TW'(WAIT_MAX)) begin
                  err   <= 1'b1;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            RES: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  if (blk_i == num_blk_l - N_W'(1)) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     blk_i    <= blk_i + N_W'(1);
                     mem_rd   <= 1'b1;
                     mem_addr <= pix_addr(blk_base_l, area_base_l, blk_i + N_W'(1), 7'd0);
                     rd_blk   <= 1'b1;
                     rd_cnt   <= 7'd1;
                     state    <= FETCH;
                  end
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_me_job_sched.sv
// Randomised bench for me_job_sched: memory and engine models, pixel/result
// logs, and a per-job schedule predicted from block count, latencies and stalls.
module tb_me_job_sched;
   localparam int ADDR_W   = 16;
   localparam int N_W      = 8;
   localparam int WAIT_MAX = 16;

   logic clk = 1'b0;
   logic rst, start;
   logic [N_W-1:0] num_blk;
   logic [ADDR_W-1:0] blk_base, area_base;
   logic busy, done, err, mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0] mem_rdata;
   logic me_block_valid, me_area_valid;
   logic [7:0] me_data;
   logic me_out_valid;
   logic signed [2:0] me_out_vector;
   logic res_valid, res_ready;
   logic [N_W-1:0] res_idx;
   logic signed [2:0] res_mvx, res_mvy;

   always #5 clk = ~clk;

   me_job_sched #(.ADDR_W(ADDR_W), .N_W(N_W), .WAIT_MAX(WAIT_MAX)) dut (
      .clk(clk), .rst(rst), .start(start), .num_blk(num_blk),
      .blk_base(blk_base), .area_base(area_base), .busy(busy), .done(done),
      .err(err), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .me_block_valid(me_block_valid), .me_area_valid(me_area_valid),
      .me_data(me_data), .me_out_valid(me_out_valid),
      .me_out_vector(me_out_vector), .res_valid(res_valid),
      .res_ready(res_ready), .res_idx(res_idx), .res_mvx(res_mvx),
      .res_mvy(res_mvy)
   );

   logic [7:0] mem [0:65535];
   initial for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
   always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_err = 0;
   task automatic check(input string tag, input logic signed [31:0] got,
                        input logic signed [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Per-block stimulus tables: engine latency, vector, consumer stall.
   int lat_t [256];
   int stall_t [256];
   logic signed [2:0] vx_t [256];
   logic signed [2:0] vy_t [256];
   int  eng_mode = 0;        // 0 normal, 1 silent, 2 x beat only
   bit  idle_ready = 1'b1;
   int  eng_acnt = 0, eng_blk = 0;
   int  drv_n = 0;

   typedef struct {int c; bit area; logic [7:0] d;} strb_t;
   strb_t sq[$];
   int tq[$], rq[$], dq[$];
   int rd_cnt = 0;

   // Output monitor: logs strobes/reads/done, checks results every valid cycle.
   initial begin
      bit prev_rv;
      prev_rv = 1'b0;
      forever begin
         @(negedge clk);
         if (me_block_valid || me_area_valid) sq.push_back('{cyc, me_area_valid, me_data});
         if (mem_rd) rd_cnt++;
         if (done) dq.push_back(cyc);
         if (res_valid) begin
            if (!prev_rv) rq.push_back(cyc);
            check("res_idx", res_idx, tq.size());
            check("res_mvx", res_mvx, vx_t[tq.size() % 256]);
            check("res_mvy", res_mvy, vy_t[tq.size() % 256]);
            if (res_ready) tq.push_back(cyc);
         end
         prev_rv = res_valid;
      end
   end

   // Engine model: answers after the 64th area strobe of each block.
   initial begin
      int ek;
      me_out_valid  = 1'b0;
      me_out_vector = '0;
      forever begin
         @(negedge clk);
         if (me_area_valid) begin
            eng_acnt++;
            if (eng_acnt == 64) begin
               eng_acnt = 0;
               ek = eng_blk % 256;
               eng_blk++;
               if (eng_mode != 1) begin
                  repeat (lat_t[ek]) @(posedge clk);
                  #1 me_out_valid = 1'b1;
                  me_out_vector = vx_t[ek];
                  @(posedge clk);
                  #1;
                  if (eng_mode == 2) me_out_valid = 1'b0;
                  else me_out_vector = vy_t[ek];
                  @(posedge clk);
                  #1 me_out_valid = 1'b0;
                  me_out_vector = 3'($urandom);
               end
            end
         end
      end
   end

   // Consumer: stalls each result for its table entry, noisy ready when idle.
   initial begin
      bit drv_prev;
      int stall_left;
      drv_prev = 1'b0;
      stall_left = 0;
      res_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (res_valid) begin
            if (!drv_prev) begin
               stall_left = stall_t[drv_n % 256];
               drv_n++;
            end
            res_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
         end else begin
            res_ready = idle_ready ? 1'b1 : 1'($urandom_range(0, 1));
         end
         drv_prev = res_valid;
      end
   end

   task automatic rand_tabs();
      for (int k = 0; k < 256; k++) begin
         lat_t[k]   = $urandom_range(1, WAIT_MAX);
         stall_t[k] = $urandom_range(0, 5);
         vx_t[k]    = 3'(int'($urandom_range(0, 4)) - 2);
         vy_t[k]    = 3'(int'($urandom_range(0, 4)) - 2);
      end
   endtask

   task automatic run_job(input int n, input logic [15:0] bb, input logic [15:0] ab,
                          input int mode, input bit inj);
      int S, s, L, R, T, exp_done, nblk, nres, budget, idx;
      logic [15:0] a;
      sq.delete(); tq.delete(); rq.delete(); dq.delete();
      rd_cnt = 0; eng_acnt = 0; eng_blk = 0; eng_mode = mode; drv_n = 0;
      @(posedge clk);
      #1 start = 1'b1;
      num_blk = N_W'(n); blk_base = bb; area_base = ab;
      S = cyc;
      @(posedge clk);
      #1 start = 1'b0;
      num_blk = N_W'($urandom); blk_base = 16'($urandom); area_base = 16'($urandom);
      @(negedge clk);
      check("busy_after_start", busy, 1);
      check("err_cleared", err, 0);
      #1;
      budget = 200 * (n + 2);
      for (int w = 0; w < budget && dq.size() == 0; w++) begin
         @(posedge clk);
         #1 start = (inj && w == 40);
      end
      start = 1'b0;
      check("done_seen", dq.size() > 0, 1);
      @(negedge clk);
      check("busy_after_done", busy, 0);
      check("done_one_cycle", done, 0);
      s = S; nblk = 0; nres = 0; exp_done = S + 1;
      for (int k = 0; k < n; k++) begin
         nblk++;
         L = s + 81;
         for (int j = 0; j < 80; j++) begin
            idx = k * 80 + j;
            if (idx < sq.size()) begin
               a = (j < 16) ? bb + 16'(16 * k + j) : ab + 16'(64 * k + j - 16);
               check("pix_cycle", sq[idx].c, s + 2 + j);
               check("pix_kind", sq[idx].area, j >= 16);
               check("pix_data", sq[idx].d, mem[a]);
            end
         end
         if (mode == 1) begin exp_done = L + WAIT_MAX + 1; break; end
         if (mode == 2) begin exp_done = L + lat_t[k] + 2; break; end
         nres++;
         R = L + lat_t[k] + 2;
         T = R + stall_t[k];
         if (k < rq.size()) check("res_valid_rise", rq[k], R);
         if (k < tq.size()) check("transfer_cycle", tq[k], T);
         s = T;
         exp_done = T + 1;
      end
      check("n_strobes", sq.size(), 80 * nblk);
      check("n_reads", rd_cnt, 80 * nblk);
      check("n_results", tq.size(), nres);
      check("n_done", dq.size(), 1);
      if (dq.size() > 0) check("done_cycle", dq[0], exp_done);
      check("err_final", err, (mode != 0) ? 1 : 0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_err"}, err, 0);
      check({tag, "_mem_rd"}, mem_rd, 0);
      check({tag, "_mem_addr"}, mem_addr, 0);
      check({tag, "_blk_v"}, me_block_valid, 0);
      check({tag, "_area_v"}, me_area_valid, 0);
      check({tag, "_res_valid"}, res_valid, 0);
      check({tag, "_res_idx"}, res_idx, 0);
      check({tag, "_res_mvx"}, res_mvx, 0);
      check({tag, "_res_mvy"}, res_mvy, 0);
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; num_blk = '0; blk_base = '0; area_base = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_vals("reset");
      #1 rst = 1'b0;

      // Single block, vector (+1,-1)
      rand_tabs();
      lat_t[0] = 3; vx_t[0] = 3'sd1; vy_t[0] = -3'sd1; stall_t[0] = 0;
      idle_ready = 1'b1;
      run_job(1, 16'h0000, 16'h1000, 0, 1'b0);

      // Three blocks, ready tied high, start pulsed mid-job
      rand_tabs();
      for (int k = 0; k < 3; k++) stall_t[k] = 0;
      run_job(3, 16'h0200, 16'h4000, 0, 1'b1);

      // Backpressure on block 0
      rand_tabs();
      stall_t[0] = 10; stall_t[1] = 0;
      idle_ready = 1'b0;
      run_job(2, 16'h3000, 16'h5000, 0, 1'b0);

      // Engine silent: timeout aborts the job, then a clean job clears err
      rand_tabs();
      run_job(2, 16'h0100, 16'h0800, 1, 1'b0);
      rand_tabs();
      run_job(1, 16'h0140, 16'h0900, 0, 1'b0);

      // Only the x beat arrives
      rand_tabs();
      run_job(1, 16'h2000, 16'h2100, 2, 1'b0);

      // Empty job and address wrap
      run_job(0, 16'h1234, 16'h5678, 0, 1'b0);
      rand_tabs();
      run_job(2, 16'hFFF8, 16'hFFE0, 0, 1'b0);

      // Reset in the middle of FETCH, then a fresh job
      @(posedge clk);
      #1 start = 1'b1; num_blk = 8'd3; blk_base = 16'h0400; area_base = 16'h0600;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (39) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_reset_vals("midreset");
      rand_tabs();
      run_job(2, 16'h0400, 16'h0600, 0, 1'b0);

      // Randomised jobs
      for (int r = 0; r < 6; r++) begin
         rand_tabs();
         idle_ready = 1'($urandom_range(0, 1));
         run_job($urandom_range(1, 4), 16'($urandom), 16'($urandom), 0, 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/me_job_sched.md
# me_job_sched

Job scheduler for the 4x4 SAD motion-estimation engine. It accepts a job of N blocks from a host, fetches each 16-pixel current block and its 64-pixel (8x8) search area from a byte-wide synchronous memory, and streams them gap-free into the engine. It collects the two-beat motion vector (x, then y) and hands each result to a downstream consumer over a valid/ready handshake. One block is in flight at a time.

## Interface
- ADDR_W, 16, memory address width; all address arithmetic wraps modulo 2^ADDR_W
- N_W, 8, width of block count and result index
- WAIT_MAX, 16, maximum cycles to wait for the engine's first out_valid beat after the last area pixel
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle job request; sampled only in IDLE
- num_blk  in  N_W  blocks in job; latched with start
- blk_base  in  ADDR_W  address of block 0 pixels; latched with start
- area_base  in  ADDR_W  address of area 0 pixels; latched with start
- busy  out  1  high from the cycle after an accepted start until the done cycle, inclusive
- done  out  1  one-cycle pulse at job end (normal or abort)
- err  out  1  sticky engine-timeout/protocol flag; cleared by the next accepted start
- mem_rd  out  1  memory read strobe
- mem_addr  out  ADDR_W  read address; data returns on mem_rdata exactly 1 cycle later
- mem_rdata  in  8  read data
- me_block_valid  out  1  engine block-pixel strobe
- me_area_valid  out  1  engine area-pixel strobe
- me_data  out  8  engine pixel bus; combinational copy of mem_rdata
- me_out_valid  in  1  engine result strobe (2 consecutive beats)
- me_out_vector  in  3 signed  engine result (beat 1 = x, beat 2 = y)
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_idx  out  N_W  block index 0..num_blk-1
- res_mvx, res_mvy  out  3 signed  vector, range -2..2

## Operation
- States: IDLE, FETCH, WAIT, RES, DONE.
- IDLE: on start, latch inputs, clear err, set blk index i=0; if num_blk==0 go to DONE, else go to FETCH with read counter c=0.
- FETCH: 80 cycles, mem_rd=1 every cycle. For c=0..15, mem_addr=blk_base+16*i+c. For c=16..79, mem_addr=area_base+64*i+(c-16). me_block_valid and me_area_valid are the registered (1-cycle-delayed) read strobes: block for reads 0..15, area for reads 16..79. The 80 pixel strobes are contiguous and have no gaps, and area strobes directly follow block strobes. This is mandatory for the engine. After c=79, go to WAIT with timeout counter t=0.
- WAIT: count t each cycle. On the first me_out_valid, capture x. Capture y on the next cycle. If me_out_valid is low on that next cycle, set err and go to DONE. If t reaches WAIT_MAX+1 with no beat (the count begins after the last area strobe), set err and go to DONE. After both beats, go to RES.
- RES: res_valid=1 with res_idx=i, res_mvx, res_mvy held stable until res_ready. On the transfer cycle, if i==num_blk-1 go to DONE; else increment i and go to FETCH.
- DONE: done=1 for one cycle, then go to IDLE.
- me_out_valid outside WAIT is ignored.
- start outside IDLE is ignored.
- rst overrides everything. The state machine returns to IDLE and the in-flight job is dropped. The engine itself is not reset; the next block_valid burst re-initialises it.

## Timing
- Reset values: busy=0, done=0, err=0, mem_rd=0, mem_addr=0, me_block_valid=0, me_area_valid=0, res_valid=0, res_idx=0, res_mvx=0, res_mvy=0. me_data follows mem_rdata and is don't-care while strobes are low.
- Start is accepted at cycle 0. The first mem_rd is at cycle 1. me_block_valid is high in cycles 2..17 and me_area_valid in cycles 18..81.
- res_valid rises the cycle after the y beat. A transfer occurs on any cycle where res_valid && res_ready, including the first cycle of res_valid.
- The next block's first mem_rd is the cycle after the transfer.
- done is asserted the cycle after the final transfer, or the cycle after the error is detected. busy falls after the done cycle.
- Per-block cost: 80 + engine latency + 2 + RES-wait + 1 cycles.

## Test plan
- Single block: num_blk=1, blk_base=0x0000, area_base=0x1000, with the area equal to the block at offset (+1,-1) and the engine model returning x=1, y=-1. Expect 16 block strobes at cycles 2..17, 64 area strobes at 18..81, then res_valid with idx=0, mvx=1, mvy=-1, then done; err=0.
- Three blocks with res_ready tied high. Addresses for block i=2 start at blk_base+32 and area_base+128. Expect three results with idx 0,1,2 in order and exactly one done pulse.
- Backpressure: res_ready held low for 10 cycles on block 0. Expect res_idx, res_mvx and res_mvy stable for the whole stall, and no mem_rd until the cycle after the transfer.
- Timeout: engine model never asserts out_valid. Expect err=1 and done exactly WAIT_MAX+1 cycles after the last area strobe. A following start clears err.
- Boundary cases: num_blk=0 gives done at cycle 1 and no mem_rd. blk_base=0xFFF8 wraps to 0x0007 for pixel 15. Start asserted while busy is ignored.
- Reset mid-FETCH at cycle 40: expect all outputs at reset values the next cycle. A new start then runs cleanly from block 0.
